// File: rtl/rsa_com_pkg.sv
// Shared definitions for the CPU <-> external interpreter byte link.
// Holds the inbound receiver FSM state type and the link byte/word geometry.
// The outbound link logic uses the same geometry constants.
package rsa_com_pkg;

  localparam int COM_BYTE_W     = 8;
  localparam int COM_WORD_W     = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    ACK   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous level, plus its synced level
// and a single-cycle rising-edge pulse.
// Ports:
//   clk      system clock
//   reset    synchronous reset, active-low
//   d_i      asynchronous input
//   level_o  synchronized level (last stage)
//   rise_o   one-cycle pulse on a synced 0->1 transition
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;

  // The stages clear to 0 on reset, so for SYNC_STAGES cycles afterwards the
  // last stage does not yet reflect the pin. fill_q tracks when the chain holds
  // real samples; until then prev_q is pinned at 1, so a strobe that was
  // already high through reset is never mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= fill_q[SYNC_STAGES-1] ? sync_q[SYNC_STAGES-1] : 1'b1;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;

endmodule

// File: rtl/interpreter_receiver.sv
// Inbound end of the interpreter byte link. Receives host bytes over a
// 4-phase strobe/ack handshake, packs them little-endian into 32-bit words and
// writes each word to data memory through the shared write port. Raises
// LoadDone after NUM_WORDS writes.
// Ports:
//   clk, reset         system clock, synchronous active-low reset
//   enable             load window open; low aborts / returns to idle
//   clk_in, DataIn     host strobe and byte (asynchronous to clk)
//   ack                byte-accepted handshake back to the host
//   MemWrite           one-cycle write enable
//   DataAddress        byte address of the word being written
//   WriteData          assembled word
//   LoadDone           all NUM_WORDS words written
module interpreter_receiver
  import rsa_com_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_WORDS   = 16,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clk_in,
  input  logic [7:0]  DataIn,
  output logic        ack,
  output logic        MemWrite,
  output logic [31:0] DataAddress,
  output logic [31:0] WriteData,
  output logic        LoadDone
);

  localparam int IW = $clog2(NUM_WORDS + 1);

  rx_state_t                               state_q, state_d;
  logic                                    ack_q, ack_d;
  logic                                    mw_q, mw_d;
  logic                                    done_q, done_d;
  logic [COM_WORD_W-1:0]                   addr_q, addr_d;
  logic [COM_WORD_W-1:0]                   wdata_q, wdata_d;
  logic [COM_WORD_W-1:0]                   word_q, word_d;
  logic [1:0]                              byte_cnt_q, byte_cnt_d;
  logic [IW-1:0]                           word_idx_q, word_idx_d;
  logic [SYNC_STAGES-1:0][COM_BYTE_W-1:0]  din_sync_q;
  logic                                    strobe_lvl, strobe_rise;
  logic                                    go_idle;
  logic                                    last_word;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk     (clk),
    .reset   (reset),
    .d_i     (clk_in),
    .level_o (strobe_lvl),
    .rise_o  (strobe_rise)
  );

  // DataIn is held stable by the host around the strobe, so a plain vector
  // synchronizer of equal depth keeps it aligned with the synced strobe.
  always_ff @(posedge clk) begin
    if (!reset) din_sync_q <= '0;
    else        din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], DataIn};
  end

  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(NUM_WORDS);

  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    mw_d       = 1'b0;
    done_d     = done_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    go_idle    = 1'b0;
    unique case (state_q)
      IDLE: begin
        go_idle = 1'b1;
        if (enable) state_d = RECV;
      end
      RECV: begin
        if (!enable) go_idle = 1'b1;
        else if (strobe_rise) begin
          word_d[{byte_cnt_q, 3'b000} +: COM_BYTE_W] = din_sync_q[SYNC_STAGES-1];
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        // A second rise cannot happen here before the strobe is seen low; only the level matters.
        if (!enable) go_idle = 1'b1;
        else if (!strobe_lvl) begin
          ack_d = 1'b0;
          if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
            byte_cnt_d = '0;
            state_d    = WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            state_d    = RECV;
          end
        end
      end
      WRITE: begin
        // The write is committed even if enable has just dropped.
        mw_d       = 1'b1;
        addr_d     = BASE_ADDR + (32'(word_idx_q) << 2);
        wdata_d    = word_q;
        word_idx_d = word_idx_q + IW'(1);
        if (!enable) go_idle = 1'b1;
        else if (last_word) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else state_d = RECV;
      end
      DONE: begin
        if (!enable) go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase
    // Entering (or sitting in) IDLE discards all session progress.
    if (go_idle) begin
      if (state_q != IDLE) state_d = IDLE;
      ack_d      = 1'b0;
      done_d     = 1'b0;
      byte_cnt_d = '0;
      word_idx_d = '0;
      word_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      mw_q       <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      mw_q       <= mw_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
    end
  end

  assign ack         = ack_q;
  assign MemWrite    = mw_q;
  assign DataAddress = addr_q;
  assign WriteData   = wdata_q;
  assign LoadDone    = done_q;

endmodule

// File: tb/tb_interpreter_receiver.sv
// Self-checking bench for interpreter_receiver (NUM_WORDS=2, SYNC_STAGES=2).
module tb_interpreter_receiver;
  import rsa_com_pkg::*;

  localparam int          NW   = 2;
  localparam int          SS   = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, enable, clk_in;
  logic [7:0]  DataIn;
  logic        ack, MemWrite, LoadDone;
  logic [31:0] DataAddress, WriteData;

  interpreter_receiver #(.BASE_ADDR(BASE), .NUM_WORDS(NW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clk_in(clk_in), .DataIn(DataIn),
    .ack(ack), .MemWrite(MemWrite), .DataAddress(DataAddress),
    .WriteData(WriteData), .LoadDone(LoadDone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Session model: bytes accepted so far, word index, expected writes.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    bit          last;
  } wr_t;

  logic [7:0]  mbytes[$];
  int          mwidx    = 0;
  wr_t         exp_q[$];
  bit          exp_done = 1'b0;
  logic [31:0] hold_a   = '0;
  logic [31:0] hold_d   = '0;
  int          nwrites  = 0;
  logic [31:0] last_a   = '0;
  logic [31:0] last_d   = '0;
  int          ack_rises = 0;
  logic        ack_prev  = 1'b0;

  function automatic void model_byte(input logic [7:0] b);
    wr_t w;
    mbytes.push_back(b);
    if (mbytes.size() == 4) begin
      w.d    = {mbytes[3], mbytes[2], mbytes[1], mbytes[0]};
      w.a    = BASE + 32'(mwidx) * 32'd4;
      w.last = (mwidx + 1 == NW);
      exp_q.push_back(w);
      mwidx++;
      mbytes.delete();
    end
  endfunction

  function automatic void model_clear();
    mbytes.delete();
    mwidx    = 0;
    exp_done = 1'b0;
  endfunction

  // Per-cycle compare against the model.
  initial begin
    logic r;
    wr_t  e;
    forever begin
      @(posedge clk);
      r = reset;
      #1;
      if (r !== 1'b1) begin
        hold_a   = '0;
        hold_d   = '0;
        exp_done = 1'b0;
      end
      if (MemWrite === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_write", 32'(MemWrite), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", DataAddress, e.a);
          chk("wr_data", WriteData, e.d);
          if (e.last) exp_done = 1'b1;
          hold_a = e.a;
          hold_d = e.d;
          last_a = DataAddress;
          last_d = WriteData;
          nwrites++;
        end
      end else begin
        chk("hold_addr", DataAddress, hold_a);
        chk("hold_data", WriteData, hold_d);
      end
      chk("load_done", 32'(LoadDone), 32'(exp_done));
      if (ack === 1'b1 && ack_prev !== 1'b1) ack_rises++;
      ack_prev = ack;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit exp_ack);
    int  cnt;
    bit  seen;
    @(negedge clk) DataIn = b;
    @(negedge clk) clk_in = 1'b1;
    cnt  = 0;
    seen = 1'b0;
    if (exp_ack) begin
      while (!seen && cnt < 20) begin
        @(negedge clk);
        cnt++;
        if (ack === 1'b1) seen = 1'b1;
      end
      chk("ack_seen", 32'(seen), 32'd1);
      chk("ack_latency", 32'(cnt), 32'(SS + 1));
      clk_in = 1'b0;
      cnt = 0;
      while (ack !== 1'b0 && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      chk("ack_fall", 32'(ack), 32'd0);
      model_byte(b);
    end else begin
      repeat (10) begin
        @(negedge clk);
        if (ack !== 1'b0) seen = 1'b1;
      end
      chk("no_ack", 32'(seen), 32'd0);
      clk_in = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic abort_one();
    @(negedge clk);
    enable = 1'b0;
    model_clear();
    @(negedge clk);
    enable = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0;
    reset = 1'b0; enable = 1'b0; clk_in = 1'b1; DataIn = 8'h00;
    // 1: reset with strobe held high
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_mw", 32'(MemWrite), 32'd0);
    chk("rst_done", 32'(LoadDone), 32'd0);
    chk("rst_addr", DataAddress, 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    reset = 1'b1; enable = 1'b1;
    repeat (8) @(negedge clk);
    chk("held_strobe_no_ack", 32'(ack_rises), 32'd0);
    clk_in = 1'b0;
    repeat (4) @(negedge clk);

    // 2: one word
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
    repeat (3) @(negedge clk);
    chk("t2_ack_count", 32'(ack_rises), 32'd4);
    chk("t2_writes", 32'(nwrites), 32'd1);
    chk("t2_addr", last_a, 32'h0000_0000);
    chk("t2_data", last_d, 32'h4433_2211);
    abort_one();

    // 3: full session of NUM_WORDS=2, then extra strobe ignored
    w0 = nwrites;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1);
    repeat (3) @(negedge clk);
    chk("t3_writes", 32'(nwrites - w0), 32'd2);
    chk("t3_addr", last_a, 32'h0000_0004);
    chk("t3_data", last_d, 32'h0807_0605);
    chk("t3_done", 32'(LoadDone), 32'd1);
    send_byte(8'h09, 0);
    chk("t3_done_held", 32'(LoadDone), 32'd1);
    abort_one();

    // 4: partial word discarded by enable drop
    w0 = nwrites;
    send_byte(8'hAA, 1); send_byte(8'hBB, 1);
    abort_one();
    repeat (2) @(negedge clk);
    chk("t4_no_write", 32'(nwrites), 32'(w0));
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1);
    repeat (3) @(negedge clk);
    chk("t4_writes", 32'(nwrites - w0), 32'd1);
    chk("t4_addr", last_a, 32'h0000_0000);
    chk("t4_data", last_d, 32'h0403_0201);
    abort_one();

    // 5: enable drops during WRITE of word 0
    w0 = nwrites;
    send_byte(8'hDE, 1); send_byte(8'hAD, 1); send_byte(8'hBE, 1); send_byte(8'hEF, 1);
    enable = 1'b0;
    model_clear();
    @(negedge clk);
    chk("t5_state_idle", 32'(dut.state_q), 32'(IDLE));
    chk("t5_write_seen", 32'(nwrites - w0), 32'd1);
    chk("t5_data", last_d, 32'hEFBE_ADDE);
    chk("t5_done", 32'(LoadDone), 32'd0);
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // 6: reset while ack is high
    @(negedge clk) DataIn = 8'h5A;
    @(negedge clk) clk_in = 1'b1;
    for (int i = 0; i < 20 && ack !== 1'b1; i++) @(negedge clk);
    chk("t6_ack_high", 32'(ack), 32'd1);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    chk("t6_ack_cleared", 32'(ack), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    r0 = ack_rises;
    repeat (6) @(negedge clk);
    chk("t6_no_false_edge", 32'(ack_rises), 32'(r0));
    clk_in = 1'b0;
    repeat (4) @(negedge clk);
    w0 = nwrites;
    send_byte(8'h10, 1); send_byte(8'h11, 1); send_byte(8'h12, 1); send_byte(8'h13, 1);
    repeat (3) @(negedge clk);
    chk("t6_writes", 32'(nwrites - w0), 32'd1);
    chk("t6_addr", last_a, 32'h0000_0000);
    chk("t6_data", last_d, 32'h1312_1110);

    repeat (4) @(negedge clk);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
